// File: rtl/load_sched_pkg.sv
// Shared types and link mode codes for the program-load scheduler.
// Mode codes mirror the driver's mode_out encoding.
package load_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_GAP   = 3'd3,
    S_ACK   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_INSTR = 2'b01;
  localparam logic [1:0] MODE_DATA  = 2'b10;
  localparam logic [1:0] MODE_FIN   = 2'b11;

endpackage

// File: rtl/load_sched_if.sv
// Requester and link signals of the load scheduler.
// master = requesters/driver side, slave = scheduler.
interface load_sched_if #(
  parameter int NREQ = 2,
  parameter int IMGW = 2
);

  logic [NREQ-1:0]      req_in;
  logic [NREQ*IMGW-1:0] img_in;
  logic [NREQ-1:0]      grant_out;
  logic [NREQ-1:0]      ack_out;
  logic [NREQ-1:0]      err_out;
  logic                 drive_out;
  logic [IMGW-1:0]      img_sel_out;
  logic [1:0]           mode_in;
  logic                 busy_out;
  logic                 cpu_run_out;

  modport master (
    output req_in,
    output img_in,
    output mode_in,
    input  grant_out,
    input  ack_out,
    input  err_out,
    input  drive_out,
    input  img_sel_out,
    input  busy_out,
    input  cpu_run_out
  );

  modport slave (
    input  req_in,
    input  img_in,
    input  mode_in,
    output grant_out,
    output ack_out,
    output err_out,
    output drive_out,
    output img_sel_out,
    output busy_out,
    output cpu_run_out
  );

endinterface

// File: rtl/load_sched_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr, or
// fixed lowest-index priority when LOAD_SCHED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

`ifdef LOAD_SCHED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    int j;
    logic found;
    j = 0;
    found = 1'b0;
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef LOAD_SCHED_PRIO_EN
      j = i;
`else
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
`endif
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_sched.sv
// Serial program-load link scheduler: arbitrates requesters,
// runs one session per grant. Option macro: LOAD_SCHED_PRIO_EN.
module load_sched
  import load_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IMGW    = 2,
  parameter int TMO_CYC = 1024,
  parameter int GAP_CYC = 4
) (
  input logic         clk,
  input logic         rst_n,
  load_sched_if.slave bus
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TMO_CYC);
  localparam int GW  = $clog2(GAP_CYC) + 1;

  state_t          state, nstate;
  logic [NREQ-1:0] gnt_w, grant_q;
  logic [PW-1:0]   win_w, gidx_q;
  logic [PW-1:0]   ptr_q, ptr_nxt;
  logic [IMGW-1:0] img_w, img_q;
  logic [WDW-1:0]  wd_q;
  logic [GW-1:0]   gap_q;
  logic            tmo_q, run_q;
  logic            wd_hit, gap_hit, live;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req (bus.req_in),
    .ptr (ptr_q),
    .gnt (gnt_w)
  );

  always_comb begin
    win_w = '0;
    img_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_w[i]) begin
        win_w = PW'(i);
        img_w = bus.img_in[i*IMGW +: IMGW];
      end
    end
  end

  assign live    = (state == S_LOAD)
                || (state == S_DRAIN);
  assign wd_hit  = wd_q == WDW'(TMO_CYC - 1);
  assign gap_hit = gap_q == GW'(GAP_CYC - 1);
  assign ptr_nxt = (gidx_q == PW'(NREQ - 1))
                 ? '0 : gidx_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // watchdog wins over any mode_in change in the same cycle
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:
        if (|bus.req_in) nstate = S_LOAD;
      S_LOAD:
        if (wd_hit) nstate = S_GAP;
        else if (bus.mode_in == MODE_FIN)
          nstate = S_DRAIN;
      S_DRAIN:
        if (wd_hit) nstate = S_GAP;
        else if (bus.mode_in == MODE_IDLE)
          nstate = S_GAP;
      S_GAP:
        if (gap_hit)
          nstate = tmo_q ? S_ERR : S_ACK;
      S_ACK:   nstate = S_IDLE;
      S_ERR:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      gidx_q  <= '0;
      img_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      tmo_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      gap_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (|bus.req_in) begin
            grant_q <= gnt_w;
            gidx_q  <= win_w;
            img_q   <= img_w;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
            run_q   <= 1'b0;
          end
        end
        S_LOAD, S_DRAIN: begin
          if (wd_hit) tmo_q <= 1'b1;
          else        wd_q  <= wd_q + WDW'(1);
        end
        S_GAP: begin
          if (!gap_hit) gap_q <= gap_q + GW'(1);
          else          gap_q <= gap_q;
        end
        S_ACK: begin
          grant_q <= '0;
          run_q   <= 1'b1;
          ptr_q   <= ptr_nxt;
        end
        S_ERR: begin
          grant_q <= '0;
          run_q   <= 1'b0;
          ptr_q   <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.drive_out   = live;
    bus.busy_out    = state != S_IDLE;
    bus.grant_out   = grant_q;
    bus.img_sel_out = img_q;
    bus.cpu_run_out = run_q;
    bus.ack_out     = (state == S_ACK)
                    ? grant_q : '0;
    bus.err_out     = (state == S_ERR)
                    ? grant_q : '0;
  end

endmodule

// File: tb/tb_load_sched.sv
// Directed self-checking bench for load_sched.
// Define LOAD_SCHED_PRIO_EN to exercise the fixed-priority build.
module tb_load_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  load_sched_if #(.NREQ(2), .IMGW(2)) bus ();

  load_sched #(
    .NREQ    (2),
    .IMGW    (2),
    .TMO_CYC (1024),
    .GAP_CYC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // starts in IDLE with a request pending
  task automatic session(input logic [1:0] g,
                         input string tag);
    tick(1);
    chk({tag, " grant"}, 32'(bus.grant_out), 32'(g));
    chk({tag, " drive"}, 32'(bus.drive_out), 1);
    bus.mode_in = 2'b11;
    tick(1);
    bus.mode_in = 2'b00;
    tick(1);
    chk({tag, " gap"}, 32'(bus.drive_out), 0);
    tick(4);
    chk({tag, " ack"}, 32'(bus.ack_out), 32'(g));
    tick(1);
    chk({tag, " rel"}, 32'(bus.grant_out), 0);
  endtask

  initial begin
    bus.req_in  = '0;
    bus.img_in  = '0;
    bus.mode_in = 2'b00;

    // reset state
    #2;
    chk("rst grant", 32'(bus.grant_out), 0);
    chk("rst drive", 32'(bus.drive_out), 0);
    chk("rst busy",  32'(bus.busy_out), 0);
    chk("rst run",   32'(bus.cpu_run_out), 0);
    chk("rst img",   32'(bus.img_sel_out), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 1: single load, req0 image 2
    bus.req_in = 2'b01;
    bus.img_in = 4'b0010;
    #1;
    chk("t1 pre drive", 32'(bus.drive_out), 0);
    tick(1);
    chk("t1 drive", 32'(bus.drive_out), 1);
    chk("t1 grant", 32'(bus.grant_out), 32'h1);
    chk("t1 img",   32'(bus.img_sel_out), 2);
    bus.mode_in = 2'b01;
    tick(20);
    bus.mode_in = 2'b10;
    tick(20);
    bus.mode_in = 2'b11;
    tick(3);
    chk("t1 drain", 32'(bus.drive_out), 1);
    bus.mode_in = 2'b00;
    tick(1);
    chk("t1 low", 32'(bus.drive_out), 0);
    chk("t1 busy", 32'(bus.busy_out), 1);
    tick(3);
    chk("t1 early ack", 32'(bus.ack_out), 0);
    tick(1);
    chk("t1 ack", 32'(bus.ack_out), 32'h1);
    bus.req_in = 2'b00;
    tick(1);
    chk("t1 ack end", 32'(bus.ack_out), 0);
    chk("t1 run", 32'(bus.cpu_run_out), 1);
    chk("t1 idle", 32'(bus.busy_out), 0);

    // 2: both requesting from a fresh pointer
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    bus.req_in = 2'b11;
`ifdef LOAD_SCHED_PRIO_EN
    session(2'b01, "t6 s1");
    session(2'b01, "t6 s2");
    session(2'b01, "t6 s3");
    bus.req_in = 2'b10;
    session(2'b10, "t6 s4");
`else
    session(2'b01, "t2 s1");
    session(2'b10, "t2 s2");
    session(2'b01, "t2 s3");
    session(2'b10, "t2 s4");
`endif
    bus.req_in = 2'b00;
    tick(1);

    // 5: requester drops mid-LOAD
    bus.req_in = 2'b01;
    tick(1);
    chk("t5 grant", 32'(bus.grant_out), 32'h1);
    bus.req_in = 2'b00;
    tick(3);
    chk("t5 busy", 32'(bus.busy_out), 1);
    bus.mode_in = 2'b11;
    tick(1);
    bus.mode_in = 2'b00;
    tick(5);
    chk("t5 ack", 32'(bus.ack_out), 32'h1);
    tick(1);
    chk("t5 ack end", 32'(bus.ack_out), 0);
    tick(3);
    chk("t5 idle", 32'(bus.busy_out), 0);

    // 3: watchdog timeout, mode stuck at instr
    bus.req_in = 2'b10;
    bus.img_in = 4'b1100;
    bus.mode_in = 2'b01;
    tick(1);
    chk("t3 grant", 32'(bus.grant_out), 32'h2);
    chk("t3 img", 32'(bus.img_sel_out), 3);
    tick(1023);
    chk("t3 drive", 32'(bus.drive_out), 1);
    tick(1);
    chk("t3 drop", 32'(bus.drive_out), 0);
    tick(3);
    chk("t3 early err", 32'(bus.err_out), 0);
    tick(1);
    chk("t3 err", 32'(bus.err_out), 32'h2);
    chk("t3 noack", 32'(bus.ack_out), 0);
    chk("t3 run", 32'(bus.cpu_run_out), 0);
    bus.req_in = 2'b01;
    tick(1);
    chk("t3 err end", 32'(bus.err_out), 0);
    tick(1);
    chk("t3 next", 32'(bus.grant_out), 32'h1);

    // 4: async reset during DRAIN
    bus.mode_in = 2'b11;
    tick(1);
    chk("t4 drain", 32'(bus.drive_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4 drive", 32'(bus.drive_out), 0);
    chk("t4 grant", 32'(bus.grant_out), 0);
    chk("t4 busy",  32'(bus.busy_out), 0);
    bus.req_in = 2'b00;
    bus.mode_in = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("t4 ack", 32'(bus.ack_out), 0);
    chk("t4 err", 32'(bus.err_out), 0);
    chk("t4 idle", 32'(bus.busy_out), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
